operand_fetch_fwd: RTL
======================

Name: operand_fetch_fwd

Overview:
- Decode-stage read side of the GRF in the 5-stage MIPS pipeline.
- Drives the GRF read addresses (grf_a1/grf_a2) and receives RD1/RD2.
- Tracks destination registers of in-flight instructions in the E, M and W stages. Forwards the newest value into D, or raises stall when the operand is needed before it exists (Tuse/Tnew model).
- Register writes themselves remain in the W stage and grf.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- T_W, 2, width of Tuse/Tnew fields

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- d_valid  in  1  instruction present in D; 0 = bubble
- d_rs  in  ADDR_W  rs field of D instruction
- d_rt  in  ADDR_W  rt field of D instruction
- d_rs_tuse  in  T_W  cycles until rs is consumed; 3 = not used
- d_rt_tuse  in  T_W  cycles until rt is consumed; 3 = not used
- d_dst  in  ADDR_W  destination register of D instruction
- d_we  in  1  D instruction writes d_dst
- d_tnew  in  T_W  cycles after entering E until the result exists (ALU 1, load 2, lui/jal 0)
- grf_a1  out  ADDR_W  GRF read address 1 = d_rs
- grf_a2  out  ADDR_W  GRF read address 2 = d_rt
- grf_rd1  in  DATA_W  GRF read data 1
- grf_rd2  in  DATA_W  GRF read data 2
- e_data  in  DATA_W  result currently available in E
- m_data  in  DATA_W  result currently available in M
- w_data  in  DATA_W  result currently written by W (equals GRF WD3)
- rs_val  out  DATA_W  forwarded rs operand
- rt_val  out  DATA_W  forwarded rt operand
- rs_pend  out  1  rs matches an in-flight producer with Tnew>0 that is not stalled (later-stage forwarding required)
- rt_pend  out  1  same for rt
- stall  out  1  freeze PC and F/D, insert bubble into E

Behaviour:
- State: three stage entries E, M, W, each holding {dst[ADDR_W], tnew[T_W]}. dst = 0 means no write; d_we = 0 or d_valid = 0 is stored as dst = 0.
- Reset (reset = 0 at a rising edge): all entries dst = 0, tnew = 0.
  - After reset: stall = 0, rs_pend = rt_pend = 0, rs_val/rt_val = GRF data.
- Every clock, when not in reset:
  - M to W: W.dst = M.dst, W.tnew = sat_dec(M.tnew).
  - E to M: M.dst = E.dst, M.tnew = sat_dec(E.tnew).
  - If stall = 0: E.dst = d_dst (or 0), E.tnew = d_tnew.
  - If stall = 1: E becomes a bubble (dst = 0, tnew = 0).
  - sat_dec(x) = x - 1, floored at 0.
- Match rule, for operand X in {rs, rt} against stage S: X != 0 and X == S.dst. Register $0 never matches and always reads 0 from the GRF.
- Stall condition: stall = OR over X of (X matches E and tuse_X < E.tnew) or (X matches M and tuse_X < M.tnew).
  - The W-stage tnew is always 0 and never stalls.
  - tuse = 3 never stalls.
- Forward priority: E > M > W > GRF. Only the highest-priority matching stage is considered.
  - If its tnew = 0, the value is that stage's data (e_data/m_data/w_data).
  - If its tnew > 0, X_val = grf data and X_pend = 1. It does not fall through to older stages.
- W forwarding is mandatory: the GRF write at the end of the cycle is not visible on RD1/RD2 in the same cycle.
- Combinational paths:
  - grf_a1/grf_a2, rs_val/rt_val, rs_pend/rt_pend and stall depend combinationally on the D inputs and the registered entries.
  - No extra latency; a stall is resolved by the entry advance.
- Simultaneous events: rs and rt matching different stages are resolved independently. Any single stall cause asserts stall.
- d_valid = 0: stall = 0, pend = 0, and a bubble enters E.
- Reset mid-stall: entries are cleared, and stall drops in the cycle after the reset edge.

Decomposition:
- Package pipe_pkg:
  - ADDR_W, DATA_W, T_W
  - TUSE_NONE = 2'd3
  - stage_entry_t {dst, tnew}
  - function sat_dec
- Sub-module fwd_sel: combinational priority selector (operand, tuse, E/M/W entries, data, grf data) returning val, pend and stall_req. It is instantiated twice, once for rs and once for rt. The stage registers and the stall OR remain in the top module.

Test Plan:
- Reset low for 2 cycles with garbage inputs -> stall = 0, entries dst = 0; d_rs = 5, grf_rd1 = 0x1234 gives rs_val = 0x1234.
- ALU producer:
  - D: dst = 8, we = 1, tnew = 1.
  - Next cycle consumer rs = 8, tuse = 1, m_data = 0xAAAA_0001 -> no stall.
  - The consumer sees E match, tnew = 1, so rs_pend = 1.
  - One cycle later the M entry has tnew = 0, and forwarding from m_data gives rs_val = 0xAAAA_0001.
- Load-use:
  - Producer dst = 9, tnew = 2; next instruction rt = 9, tuse = 0 -> stall = 1 for exactly 2 cycles, with a bubble in E each cycle.
  - Then rt_val = w_data (0xDEAD_BEEF) and stall = 0.
- Priority: E.dst = M.dst = W.dst = 4, all tnew = 0, e_data = 1, m_data = 2, w_data = 3, rs = 4 -> rs_val = 1; after E clears -> 2; after M clears -> 3.
- $0: producer dst = 0, tnew = 2; consumer rs = 0, tuse = 0 -> stall = 0, rs_val = grf_rd1 (0).
- Reset asserted during a load-use stall -> the next cycle has stall = 0 and rs_val/rt_val = GRF data.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, stage-entry record and Tnew countdown helper for the
// decode-stage operand fetch / forwarding logic.
package pipe_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int T_W    = 2;

  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [T_W-1:0]    tnew;
  } stage_entry_t;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x == '0) ? '0 : x - T_W'(1);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding selector: newest matching stage wins, an unready
// producer yields GRF data plus a pending flag, and Tuse < Tnew asks for a stall.
module fwd_sel #(
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int T_W    = pipe_pkg::T_W
) (
  input  logic [ADDR_W-1:0] op,
  input  logic [T_W-1:0]    tuse,
  input  logic [ADDR_W-1:0] e_dst,
  input  logic [T_W-1:0]    e_tnew,
  input  logic [ADDR_W-1:0] m_dst,
  input  logic [T_W-1:0]    m_tnew,
  input  logic [ADDR_W-1:0] w_dst,
  input  logic [T_W-1:0]    w_tnew,
  input  logic [DATA_W-1:0] e_data,
  input  logic [DATA_W-1:0] m_data,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] grf_data,
  output logic [DATA_W-1:0] val,
  output logic              pend,
  output logic              stall_req
);

  logic match_e, match_m, match_w, uses;

  // $0 is hard-wired, so it never matches an in-flight producer
  assign match_e = (op != '0) && (op == e_dst);
  assign match_m = (op != '0) && (op == m_dst);
  assign match_w = (op != '0) && (op == w_dst);
  assign uses    = (tuse != pipe_pkg::TUSE_NONE);

  // W can never stall: its remaining Tnew has always elapsed for real producers
  assign stall_req = uses && ((match_e && (tuse < e_tnew)) ||
                              (match_m && (tuse < m_tnew)));

  always_comb begin
    val  = grf_data;
    pend = 1'b0;
    if (match_e) begin
      if (e_tnew == '0) val = e_data;
      else              pend = 1'b1;
    end else if (match_m) begin
      if (m_tnew == '0) val = m_data;
      else              pend = 1'b1;
    end else if (match_w) begin
      if (w_tnew == '0) val = w_data;
      else              pend = 1'b1;
    end
  end

endmodule

// File: rtl/operand_fetch_fwd.sv
// Decode-stage GRF read side: tracks E/M/W destination registers with their
// Tnew countdown, forwards the newest value into D and raises load-use stalls.
module operand_fetch_fwd #(
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int T_W    = pipe_pkg::T_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [T_W-1:0]    d_rs_tuse,
  input  logic [T_W-1:0]    d_rt_tuse,
  input  logic [ADDR_W-1:0] d_dst,
  input  logic              d_we,
  input  logic [T_W-1:0]    d_tnew,
  output logic [ADDR_W-1:0] grf_a1,
  output logic [ADDR_W-1:0] grf_a2,
  input  logic [DATA_W-1:0] grf_rd1,
  input  logic [DATA_W-1:0] grf_rd2,
  input  logic [DATA_W-1:0] e_data,
  input  logic [DATA_W-1:0] m_data,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] rs_val,
  output logic [DATA_W-1:0] rt_val,
  output logic              rs_pend,
  output logic              rt_pend,
  output logic              stall
);
  import pipe_pkg::*;

  stage_entry_t stage_e_p0, stage_m_p1, stage_w_p2;
  logic         rs_stall, rt_stall, rs_pend_raw, rt_pend_raw;

  assign grf_a1 = d_rs;
  assign grf_a2 = d_rt;

  fwd_sel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_W(T_W)) u_rs_sel (
    .op(d_rs), .tuse(d_rs_tuse),
    .e_dst(stage_e_p0.dst), .e_tnew(stage_e_p0.tnew),
    .m_dst(stage_m_p1.dst), .m_tnew(stage_m_p1.tnew),
    .w_dst(stage_w_p2.dst), .w_tnew(stage_w_p2.tnew),
    .e_data(e_data), .m_data(m_data), .w_data(w_data), .grf_data(grf_rd1),
    .val(rs_val), .pend(rs_pend_raw), .stall_req(rs_stall)
  );

  fwd_sel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_W(T_W)) u_rt_sel (
    .op(d_rt), .tuse(d_rt_tuse),
    .e_dst(stage_e_p0.dst), .e_tnew(stage_e_p0.tnew),
    .m_dst(stage_m_p1.dst), .m_tnew(stage_m_p1.tnew),
    .w_dst(stage_w_p2.dst), .w_tnew(stage_w_p2.tnew),
    .e_data(e_data), .m_data(m_data), .w_data(w_data), .grf_data(grf_rd2),
    .val(rt_val), .pend(rt_pend_raw), .stall_req(rt_stall)
  );

  // A bubble in D neither stalls nor waits on later-stage forwarding
  assign stall   = d_valid & (rs_stall | rt_stall);
  assign rs_pend = d_valid & rs_pend_raw & ~stall;
  assign rt_pend = d_valid & rt_pend_raw & ~stall;

  // D -> E (p0), E -> M (p1), M -> W (p2)
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_e_p0 <= '0;
      stage_m_p1 <= '0;
      stage_w_p2 <= '0;
    end else begin
      stage_w_p2.dst  <= stage_m_p1.dst;
      stage_w_p2.tnew <= sat_dec(stage_m_p1.tnew);
      stage_m_p1.dst  <= stage_e_p0.dst;
      stage_m_p1.tnew <= sat_dec(stage_e_p0.tnew);
      if (stall || !d_valid) begin
        stage_e_p0 <= '0;
      end else begin
        stage_e_p0.dst  <= d_we ? d_dst : '0;
        stage_e_p0.tnew <= d_tnew;
      end
    end
  end

endmodule
